// File: rtl/binary_to_bcd_seq_pkg.sv
// rtl/binary_to_bcd_seq_pkg.sv - shared types, constants and helpers for the sequential BCD converter
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD       = 4'd3;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/binary_to_bcd_seq_if.sv
// rtl/binary_to_bcd_seq_if.sv - start/ready/done handshake and result bundle of the converter
interface binary_to_bcd_seq_if #(
  parameter int BINARY_LENGTH = 8,
  parameter int BCD_NUMBER    = 3
);

  logic                      start;
  logic [BINARY_LENGTH-1:0]  binary_in;
  logic                      ready;
  logic                      busy;
  logic                      done;
  logic [BCD_NUMBER*4-1:0]   bcd_out;
  logic                      overflow;

  modport master (
    output start, binary_in,
    input  ready, busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, binary_in,
    output ready, busy, done, bcd_out, overflow
  );

endinterface

// File: rtl/binary_to_bcd_seq_digit_adjust.sv
// rtl/binary_to_bcd_seq_digit_adjust.sv - one double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= BCD_ADJ_THRESHOLD) ? (digit_i + BCD_ADJ_ADD) : digit_i;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// rtl/binary_to_bcd_seq.sv - double-dabble binary-to-BCD converter, one adjust/shift step per clock
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BINARY_LENGTH = 8,
  parameter int BCD_NUMBER    = 3
) (
  input logic               clk,
  input logic               rst,
  binary_to_bcd_seq_if.slave bus
);

  localparam int BCD_W = BCD_NUMBER * 4;
  localparam int SR_W  = BCD_W + BINARY_LENGTH;
  localparam int CNT_W = clog2(BINARY_LENGTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BINARY_LENGTH - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              sticky_q, sticky_d;
  logic              ovf_q, ovf_d;

  logic [BCD_W-1:0]  bcd_adj;
  logic [SR_W-1:0]   adj_full;

  for (genvar g = 0; g < BCD_NUMBER; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i(sr_q[BINARY_LENGTH + 4*g +: 4]),
      .digit_o(bcd_adj[4*g +: 4])
    );
  end

  assign adj_full = {bcd_adj, sr_q[BINARY_LENGTH-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      bcd_q    <= '0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      bcd_q    <= bcd_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    bcd_d    = bcd_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          sr_d     = {{BCD_W{1'b0}}, bus.binary_in};
          cnt_d    = '0;
          sticky_d = 1'b0;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        // A 1 leaving the top digit means the value needs more digits than we have.
        sr_d     = {adj_full[SR_W-2:0], 1'b0};
        sticky_d = sticky_q | adj_full[SR_W-1];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          bcd_d   = adj_full[SR_W-2 -: BCD_W];
          ovf_d   = sticky_q | adj_full[SR_W-1];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready    = (state_q == IDLE) || (state_q == DONE);
  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = (state_q == DONE);
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// tb/tb_binary_to_bcd_seq.sv - randomized self-checking bench for binary_to_bcd_seq against a decimal model
module tb_binary_to_bcd_seq;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  binary_to_bcd_seq_if #(.BINARY_LENGTH(8), .BCD_NUMBER(3)) bus3 ();
  binary_to_bcd_seq_if #(.BINARY_LENGTH(8), .BCD_NUMBER(2)) bus2 ();

  binary_to_bcd_seq #(.BINARY_LENGTH(8), .BCD_NUMBER(3)) u_dut3 (
    .clk(clk),
    .rst(rst),
    .bus(bus3.slave)
  );

  binary_to_bcd_seq #(.BINARY_LENGTH(8), .BCD_NUMBER(2)) u_dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: low n digits of v, and whether v needs more than n digits.
  function automatic logic [15:0] ref_bcd(input int v, input int n);
    logic [15:0] r;
    int d;
    r = '0;
    d = v;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int v, input int n);
    int lim;
    lim = 1;
    for (int i = 0; i < n; i++) lim = lim * 10;
    return (v >= lim);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic convert3(input int v, output int edges, output int busy_cycles,
                          output logic [11:0] bcd, output logic ovf, output logic held);
    logic [11:0] prev;
    prev = bus3.bcd_out;
    held = 1'b1;
    bus3.start     = 1'b1;
    bus3.binary_in = v[7:0];
    step();
    bus3.start = 1'b0;
    edges = 0;
    busy_cycles = 0;
    while (!bus3.done && edges < 30) begin
      if (bus3.busy) busy_cycles++;
      if (bus3.bcd_out !== prev) held = 1'b0;
      step();
      edges++;
    end
    bcd = bus3.bcd_out;
    ovf = bus3.overflow;
  endtask

  task automatic convert2(input int v, output int edges, output logic [7:0] bcd, output logic ovf);
    bus2.start     = 1'b1;
    bus2.binary_in = v[7:0];
    step();
    bus2.start = 1'b0;
    edges = 0;
    while (!bus2.done && edges < 30) begin
      step();
      edges++;
    end
    bcd = bus2.bcd_out;
    ovf = bus2.overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total_cnt++; if (bus3.ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus3.ready); else pass_cnt++;
    total_cnt++; if (bus3.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus3.busy); else pass_cnt++;
    total_cnt++; if (bus3.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus3.done); else pass_cnt++;
    total_cnt++; if (bus3.bcd_out !== 12'h000) $display("FAIL reset_bcd: got %h expected 000", bus3.bcd_out); else pass_cnt++;
    total_cnt++; if (bus3.overflow !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", bus3.overflow); else pass_cnt++;
  endtask

  task automatic test_single(input int v);
    int e, b;
    logic [11:0] bcd;
    logic ovf, held;
    convert3(v, e, b, bcd, ovf, held);
    total_cnt++; if (e !== 8) $display("FAIL single_latency(%0d): got %0d expected 8", v, e); else pass_cnt++;
    total_cnt++; if (b !== 8) $display("FAIL single_busy(%0d): got %0d expected 8", v, b); else pass_cnt++;
    total_cnt++; if (bcd !== ref_bcd(v, 3)) $display("FAIL single_bcd(%0d): got %h expected %h", v, bcd, ref_bcd(v, 3)); else pass_cnt++;
    total_cnt++; if (ovf !== ref_ovf(v, 3)) $display("FAIL single_ovf(%0d): got %b expected %b", v, ovf, ref_ovf(v, 3)); else pass_cnt++;
    total_cnt++; if (held !== 1'b1) $display("FAIL single_hold(%0d): got %b expected 1", v, held); else pass_cnt++;
    step();
    total_cnt++; if (bus3.done !== 1'b0) $display("FAIL single_done_pulse(%0d): got %b expected 0", v, bus3.done); else pass_cnt++;
  endtask

  task automatic test_narrow();
    int vals[3] = '{99, 100, 255};
    int e;
    logic [7:0] bcd;
    logic ovf;
    foreach (vals[i]) begin
      convert2(vals[i], e, bcd, ovf);
      total_cnt++; if (e !== 8) $display("FAIL narrow_latency(%0d): got %0d expected 8", vals[i], e); else pass_cnt++;
      total_cnt++; if (bcd !== ref_bcd(vals[i], 2)) $display("FAIL narrow_bcd(%0d): got %h expected %h", vals[i], bcd, ref_bcd(vals[i], 2)); else pass_cnt++;
      total_cnt++; if (ovf !== ref_ovf(vals[i], 2)) $display("FAIL narrow_ovf(%0d): got %b expected %b", vals[i], ovf, ref_ovf(vals[i], 2)); else pass_cnt++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    int cyc, c1, c2;
    logic [11:0] r1, r2;
    c1 = -1;
    c2 = -1;
    r1 = '0;
    r2 = '0;
    bus3.start     = 1'b1;
    bus3.binary_in = 8'd37;
    step();
    bus3.binary_in = 8'd200;
    for (cyc = 1; cyc < 40 && c2 < 0; cyc++) begin
      if (bus3.done) begin
        if (c1 < 0) begin
          c1 = cyc;
          r1 = bus3.bcd_out;
        end else begin
          c2 = cyc;
          r2 = bus3.bcd_out;
          bus3.start = 1'b0;
        end
      end
      if (c2 < 0) step();
    end
    bus3.start = 1'b0;
    check("b2b_gap", 32'(c2 - c1), 32'd9);
    check("b2b_first", {20'h0, r1}, 32'h037);
    check("b2b_second", {20'h0, r2}, 32'h200);
    step();
  endtask

  task automatic test_start_while_busy();
    int e, dones;
    bus3.start     = 1'b1;
    bus3.binary_in = 8'd50;
    step();
    bus3.start = 1'b0;
    step();
    step();
    bus3.start     = 1'b1;
    bus3.binary_in = 8'd99;
    step();
    bus3.start = 1'b0;
    e = 3;
    while (!bus3.done && e < 30) begin
      step();
      e++;
    end
    check("busy_start_latency", 32'(e), 32'd8);
    check("busy_start_bcd", {20'h0, bus3.bcd_out}, 32'h050);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus3.done) dones++;
    end
    check("busy_start_no_extra_done", 32'(dones), 32'd0);
  endtask

  task automatic test_reset_mid();
    int e, b;
    logic [11:0] bcd;
    logic ovf, held, saw_done;
    saw_done = 1'b0;
    bus3.start     = 1'b1;
    bus3.binary_in = 8'd123;
    step();
    bus3.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus3.done) saw_done = 1'b1;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rmid_ready", {31'h0, bus3.ready}, 32'd1);
    check("rmid_bcd", {20'h0, bus3.bcd_out}, 32'h000);
    check("rmid_busy", {31'h0, bus3.busy}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (bus3.done) saw_done = 1'b1;
      step();
    end
    check("rmid_no_done", {31'h0, saw_done}, 32'd0);
    convert3(123, e, b, bcd, ovf, held);
    check("rmid_reconvert", {20'h0, bcd}, 32'h123);
    step();
  endtask

  task automatic test_sweep();
    int perm[256];
    int e, b, j, t;
    logic [11:0] bcd;
    logic ovf, held;
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      convert3(perm[i], e, b, bcd, ovf, held);
      total_cnt++; if (e !== 8) $display("FAIL sweep_latency(%0d): got %0d expected 8", perm[i], e); else pass_cnt++;
      total_cnt++; if (bcd !== ref_bcd(perm[i], 3)) $display("FAIL sweep_bcd(%0d): got %h expected %h", perm[i], bcd, ref_bcd(perm[i], 3)); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b0) $display("FAIL sweep_ovf(%0d): got %b expected 0", perm[i], ovf); else pass_cnt++;
      if ($urandom_range(1, 0) == 1) begin
        step();
        total_cnt++; if (bus3.done !== 1'b0) $display("FAIL sweep_double_done(%0d): got %b expected 0", perm[i], bus3.done); else pass_cnt++;
      end
    end
    step();
  endtask

  initial begin
    pass_cnt       = 0;
    total_cnt      = 0;
    rst            = 1'b1;
    bus3.start     = 1'b0;
    bus3.binary_in = '0;
    bus2.start     = 1'b0;
    bus2.binary_in = '0;
    test_reset();
    test_single(255);
    test_single(0);
    test_narrow();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
